button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
Conditions one asynchronous mechanical input (button or switch) for the clk_in domain. It instantiates the team synchronizer, then sequences the synchronized signal through a debounce counter and a press/hold/repeat state machine. Outputs are a clean level, single-cycle press and release pulses, a long-press pulse and auto-repeat pulses. It sits between board I/O pins and UI/control logic.

Parameters:
SYNC_DEPTH, 2, flop depth of the synchronizer instance (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive cycles the raw input must differ from level_out before level_out flips (>=1)
HOLD_CYCLES, 50000000, cycles after press_out until long_out fires (>=1)
REPEAT_CYCLES, 10000000, repeat_out period once held; 0 disables repeat
ACTIVE_LOW, 0, 1 means a pressed button drives us_in low

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
us_in  input  1  unsynchronized button pin
level_out  output  1  debounced pressed level (1 = pressed)
press_out  output  1  one-cycle pulse on debounced press
release_out  output  1  one-cycle pulse on debounced release
long_out  output  1  one-cycle pulse when hold reaches HOLD_CYCLES
repeat_out  output  1  one-cycle pulse every REPEAT_CYCLES while held past long_out

Behaviour:
- One clock (clk_in). Reset rst_in is synchronous and active-high.
- raw = synchronizer s_out XOR ACTIVE_LOW. On reset the synchronizer preloads its chain with us_in.
- Reset: level_out=0; all pulse outputs 0; all counters 0; FSM in IDLE.
- Debounce, every edge:
  - If raw==level_out, deb_cnt<=0.
  - Else if deb_cnt==DEBOUNCE_CYCLES-1, level_out<=raw and deb_cnt<=0.
  - Else deb_cnt++.
- Latency: an us_in step settled before edge k sets level_out after edge k+SYNC_DEPTH+DEBOUNCE_CYCLES-1. A bounce shorter than DEBOUNCE_CYCLES produces no output change.
- press_out and release_out are registered. They are high in exactly the cycle where level_out has just risen or fallen.
- FSM states, registered, one transition per edge:
  - IDLE: on rising level -> PRESSED, hold_cnt<=0.
  - PRESSED: hold_cnt++. When hold_cnt==HOLD_CYCLES-1, long_out=1 next cycle -> HELD, rep_cnt<=0.
  - HELD: if REPEAT_CYCLES!=0, rep_cnt++. When rep_cnt==REPEAT_CYCLES-1, repeat_out=1 next cycle and rep_cnt<=0.
  - Any state: on falling level -> IDLE, counters cleared.
- Timing, with P = the cycle press_out is high: long_out high in cycle P+HOLD_CYCLES. repeat_out high in cycles P+HOLD_CYCLES+n*REPEAT_CYCLES, n>=1.
- Simultaneous events: if release and the long/repeat terminal count occur on the same edge, release wins and long_out/repeat_out stay 0.
- A press can only start from IDLE. long_out fires at most once per press.
- Reset mid-operation returns everything to reset values. If the button is still held, a fresh press follows DEBOUNCE_CYCLES edges after rst_in deasserts, because the chain is preloaded.
- Widths: each counter is $clog2(max count + 1) bits. No wrap-around is possible, since every counter clears at its terminal value.

Decomposition:
- Shared package btn_pkg:
  - typedef enum logic [1:0] btn_state_t {BTN_IDLE, BTN_PRESSED, BTN_HELD}
  - localparam helper for counter width
- Sub-modules:
  - Instantiate the existing synchronizer (SYNC_DEPTH passed through).
  - Debounce logic is natural as one sub-module, debounce_core (raw in, level/rise/fall out).
  - The FSM stays in the top.

Test Plan:
Bench parameters: SYNC_DEPTH=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
1. Reset, then clean us_in 0->1 settled before edge 10 -> level_out rises after edge 15; press_out high for that single cycle only; long_out/repeat_out stay 0 for the next 19 cycles.
2. us_in toggles every 2 cycles for 12 cycles, then holds 1 -> exactly one press_out, zero release_out, no level_out glitch.
3. Press and hold for 60 cycles past P -> long_out at P+20; repeat_out at P+28, P+36, P+44, P+52; then release -> release_out once, no further repeat_out.
4. Press held for only 10 cycles of level_out -> press_out then release_out; long_out never asserts. Also release timed so falling level coincides with hold_cnt==19 -> release_out=1, long_out=0.
5. rst_in pulsed one cycle while in HELD with us_in held 1 -> all outputs 0 the cycle after reset; press_out reasserts 4 edges after rst_in deasserts; long_out follows 20 cycles later.
6. ACTIVE_LOW=1 -> us_in held 1 produces no activity; us_in 1->0 -> press_out with the same latency as scenario 1.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the button conditioner blocks.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESSED,
        BTN_HELD
    } btn_state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// Debounce core: level follows raw only after CYCLES consecutive disagreeing
// samples. rise_o/fall_o flag the edge on which level is about to flip.
module debounce_core
    import btn_pkg::*;
#(
    parameter int CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W = cnt_width(CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        flip    = 1'b0;
        if (raw_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            flip    = 1'b1;
            level_d = raw_i;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = flip & raw_i;
    assign fall_o  = flip & ~raw_i;

endmodule

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit. Reset preloads the
// chain with the current input so a held level is seen immediately.
module synchronizer #(
    parameter int DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic a_in,
    output logic s_out
);

    logic [DEPTH-1:0] chain_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            chain_q <= {DEPTH{a_in}};
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], a_in};
        end
    end

    assign s_out = chain_q[DEPTH-1];

endmodule

// File: rtl/button_conditioner.sv
// Button/switch conditioner: synchronize, debounce, then decode press,
// release, long-press and auto-repeat pulses.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int SYNC_DEPTH      = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic us_in,
    output logic level_out,
    output logic press_out,
    output logic release_out,
    output logic long_out,
    output logic repeat_out
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam int REP_W  = cnt_width((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    logic sync_out, raw, rise, fall;

    synchronizer #(.DEPTH(SYNC_DEPTH)) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .a_in   (us_in),
        .s_out  (sync_out)
    );

    assign raw = sync_out ^ (ACTIVE_LOW != 0);

    debounce_core #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .raw_i   (raw),
        .level_o (level_out),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    btn_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              press_q, press_d, release_q, release_d;
    logic              long_q, long_d, repeat_q, repeat_d;

    // The FSM reacts on the same edge the debounced level flips, so pulses
    // line up with the cycle press_out is high.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = rise;
        release_d = fall;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        if (fall) begin
            state_d = BTN_IDLE;
            hold_d  = '0;
            rep_d   = '0;
        end else begin
            case (state_q)
                BTN_IDLE: begin
                    if (rise) begin
                        state_d = BTN_PRESSED;
                        hold_d  = '0;
                    end
                end
                BTN_PRESSED: begin
                    if (hold_q == HOLD_LAST) begin
                        long_d  = 1'b1;
                        state_d = BTN_HELD;
                        hold_d  = '0;
                        rep_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                BTN_HELD: begin
                    if (REPEAT_CYCLES != 0) begin
                        if (rep_q == REP_LAST) begin
                            repeat_d = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
                default: state_d = BTN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= BTN_IDLE;
            hold_q    <= '0;
            rep_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign press_out   = press_q;
    assign release_out = release_q;
    assign long_out    = long_q;
    assign repeat_out  = repeat_q;

endmodule
